eth_tx_frame_queue: RTL and testbench
=====================================

// Module: eth_tx_frame_queue
// PURPOSE
//  Store-and-forward byte-frame queue. It sits directly upstream of one EthScheduler input port (ValInN/SoFInN/EoFInN/DataInN, ReqInN).
//  It accepts frames from a producer, commits only complete frames, and raises ReqOut while a committed frame is queued.
//  After the scheduler's ReqConfirm bit (Grant) arrives, it streams exactly one frame back-to-back, then releases ReqOut.
// PARAMETERS
//  ADDR_W   11  byte-RAM address width; capacity 2**ADDR_W entries; max frame length 2**ADDR_W-1 bytes
//  CNT_W     4  width of committed-frame counter; max queued frames 2**CNT_W-1
//  GAP_CYC   2  idle cycles after each EoF beat before ReqOut may re-assert (>=1)
// PORTS
//  Clk       in   1  single clock; all logic is on posedge
//  nRst      in   1  asynchronous, active-low reset
//  ValIn     in   1  write byte valid
//  SoFIn     in   1  first byte of frame (qualified by ValIn)
//  EoFIn     in   1  last byte of frame (qualified by ValIn); SoFIn&EoFIn = 1-byte frame
//  DataIn    in   8  write byte
//  Grant     in   1  ReqConfirm bit for this port from the scheduler
//  ReqOut    out  1  request to the scheduler (ReqInN)
//  ValOut    out  1  read byte valid
//  SoFOut    out  1  first read byte
//  EoFOut    out  1  last read byte
//  DataOut   out  8  read byte
//  FrameCnt  out  CNT_W  committed frames not yet fully sent
//  DropPulse out  1  one-cycle pulse per discarded frame
// BEHAVIOUR
//  Reset: every output = 0; pointers, FrameCnt, FSMs cleared. Any partial or queued frame is lost. Reset is async-assert, sync-release.
//  Storage: 9-bit RAM {eof,data}. wr_ptr (speculative), commit_ptr, rd_ptr, all mod 2**ADDR_W.
//  Write FSM W_IDLE/W_FRAME:
//   - ValIn&SoFIn: store at commit_ptr; go to W_FRAME. If already in W_FRAME: discard the partial frame, DropPulse, restart.
//   - ValIn in W_FRAME: store at wr_ptr, wr_ptr+1.
//   - ValIn without SoF in W_IDLE: ignore the byte, no pulse.
//   - Full = wr_ptr+1 == rd_ptr. A byte arriving when full makes the frame bad: wr_ptr rewinds to commit_ptr and the remaining bytes up to EoF are ignored; one DropPulse per frame.
//   - EoF byte with FrameCnt == max: drop the frame (same rewind and pulse).
//   - Good EoF byte is stored with eof=1; commit_ptr <= wr_ptr+1; FrameCnt+1 on the next edge.
//  Read FSM R_IDLE -> R_REQ -> R_SEND -> R_GAP -> R_IDLE:
//   - R_IDLE: if FrameCnt != 0, go to R_REQ. ReqOut is registered high from the first R_REQ cycle.
//   - R_REQ: RAM address = rd_ptr, so the head byte is prefetched. Wait for Grant.
//   - Grant sampled 1: the next cycle presents the head byte with ValOut=1, SoFOut=1. Then one byte per cycle, with no bubbles, until the eof byte (EoFOut=1).
//   - EoF beat: FrameCnt-1. ReqOut=0 from the cycle after the EoF beat. ValOut=0 in R_GAP. Stay in R_GAP for GAP_CYC cycles.
//   - Simultaneous commit and EoF beat: FrameCnt unchanged.
//   - Grant falling during R_SEND is ignored; the frame always completes.
//   - Grant is ignored outside R_REQ.
//  Outputs are registered. SoF/EoF/Data are 0 when ValOut=0.
//  Write and read never block each other; bytes free as soon as they are read.
// STRUCTURE
//  Package eth_pkg: ETH_BYTE_W=8, RAM entry layout {eof,data}, write/read FSM state encodings.
//  Sub-module eth_sdp_ram: simple dual-port RAM, 1 write port, 1 registered read port, WIDTH=9, ADDR_W.
//  Remaining logic: two FSMs, pointers, FrameCnt up/down counter.
// TESTING
//  1) Write a 4-byte frame A0..A3 (SoF on A0, EoF on A3). ReqOut rises, FrameCnt=1. Grant at cycle t gives ValOut t+1..t+4 = A0..A3 with SoF/EoF, ReqOut=0 at t+5, FrameCnt=0.
//  2) Three 1-byte frames (SoF&EoF), Grant held high: three single Val beats, each separated by ReqOut low for GAP_CYC cycles.
//  3) ADDR_W=4: write a 20-byte frame -> DropPulse once, FrameCnt=0, ReqOut never rises; a following 3-byte frame is sent intact.
//  4) SoF at byte 3 of an unfinished frame -> the first frame is dropped (DropPulse), and only the second frame is sent.
//  5) Commit a frame on the same edge as the EoF beat of the previous one -> FrameCnt stays 1 and ReqOut re-asserts after the gap.
//  6) Assert nRst mid-R_SEND -> all outputs are 0 at once. After release, ReqOut=0 and FrameCnt=0 until a new frame is written.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX frame queue: RAM entry layout and FSM encodings.
package eth_pkg;

  localparam int ETH_BYTE_W  = 8;
  localparam int ETH_ENTRY_W = ETH_BYTE_W + 1;

  typedef struct packed {
    logic                  eof;
    logic [ETH_BYTE_W-1:0] data;
  } ramEntry_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FRAME = 2'd1,
    W_DROP  = 2'd2
  } wrState_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_SEND = 2'd2,
    R_GAP  = 2'd3
  } rdState_t;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module eth_sdp_ram #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 11
) (
  input  logic              Clk,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [WIDTH-1:0]  RdData
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clk) begin
    if (WrEn) mem[WrAddr] <= WrData;
    RdData <= mem[RdAddr];
  end

endmodule

// File: rtl/eth_tx_frame_queue.sv
// Store-and-forward frame queue feeding one scheduler port: commits whole frames,
// requests while frames are queued, streams one frame per grant.
module eth_tx_frame_queue
  import eth_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             ValIn,
  input  logic             SoFIn,
  input  logic             EoFIn,
  input  logic [7:0]       DataIn,
  input  logic             Grant,
  output logic             ReqOut,
  output logic             ValOut,
  output logic             SoFOut,
  output logic             EoFOut,
  output logic [7:0]       DataOut,
  output logic [CNT_W-1:0] FrameCnt,
  output logic             DropPulse
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);

  logic [1:0]        rstSync;
  logic              rstB;
  wrState_t          wState;
  rdState_t          rState;
  logic [ADDR_W-1:0] wrPtr, commitPtr, rdPtr, rdPtrNxt, wBase;
  logic [GAP_W-1:0]  gapCnt;
  logic              wAccept, wFull, cntMax, wBad, wStore, wCommit, wAbort;
  logic              advance, sendDone;
  logic [ETH_ENTRY_W-1:0] ramQ;
  ramEntry_t         wrEntry, rdEntry;

  // Assert asynchronously, release two clocks after nRst rises.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) rstSync <= 2'b00;
    else       rstSync <= {rstSync[0], 1'b1};
  end
  assign rstB = rstSync[1];

  always_comb begin
    wBase   = SoFIn ? commitPtr : wrPtr;
    wAccept = ValIn & (SoFIn | (wState == W_FRAME));
    wFull   = (wBase + ADDR_W'(1)) == rdPtr;
    cntMax  = FrameCnt == {CNT_W{1'b1}};
    wBad    = wAccept & (wFull | (EoFIn & cntMax));
    wStore  = wAccept & ~wBad;
    wCommit = wStore & EoFIn;
    wAbort  = ValIn & SoFIn & (wState == W_FRAME);
    wrEntry = '{eof: EoFIn, data: DataIn};
    rdEntry = ramEntry_t'(ramQ);
    advance  = ((rState == R_REQ) & Grant) | ((rState == R_SEND) & ~EoFOut);
    sendDone = (rState == R_SEND) & EoFOut;
    // Address the byte after the one being launched so the RAM keeps up with one beat per cycle.
    rdPtrNxt = advance ? rdPtr + ADDR_W'(1) : rdPtr;
  end

  eth_sdp_ram #(.WIDTH(ETH_ENTRY_W), .ADDR_W(ADDR_W)) uRam (
    .Clk    (Clk),
    .WrEn   (wStore),
    .WrAddr (wBase),
    .WrData (wrEntry),
    .RdAddr (rdPtrNxt),
    .RdData (ramQ)
  );

  always_ff @(posedge Clk or negedge rstB) begin
    if (!rstB) begin
      wState    <= W_IDLE;
      wrPtr     <= '0;
      commitPtr <= '0;
      DropPulse <= 1'b0;
    end else begin
      DropPulse <= wBad | wAbort;
      if (wBad) begin
        wrPtr  <= commitPtr;
        wState <= EoFIn ? W_IDLE : W_DROP;
      end else if (wStore) begin
        wrPtr <= wBase + ADDR_W'(1);
        if (EoFIn) begin
          commitPtr <= wBase + ADDR_W'(1);
          wState    <= W_IDLE;
        end else begin
          wState <= W_FRAME;
        end
      end else if (ValIn && EoFIn && wState == W_DROP) begin
        wState <= W_IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge rstB) begin
    if (!rstB) begin
      FrameCnt <= '0;
    end else begin
      case ({wCommit, sendDone})
        2'b10:   FrameCnt <= FrameCnt + CNT_W'(1);
        2'b01:   FrameCnt <= FrameCnt - CNT_W'(1);
        default: FrameCnt <= FrameCnt;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge rstB) begin
    if (!rstB) begin
      rState  <= R_IDLE;
      rdPtr   <= '0;
      gapCnt  <= '0;
      ReqOut  <= 1'b0;
      ValOut  <= 1'b0;
      SoFOut  <= 1'b0;
      EoFOut  <= 1'b0;
      DataOut <= '0;
    end else begin
      rdPtr <= rdPtrNxt;
      case (rState)
        R_IDLE: if (FrameCnt != '0) begin
          rState <= R_REQ;
          ReqOut <= 1'b1;
        end
        R_REQ: if (Grant) begin
          rState  <= R_SEND;
          ValOut  <= 1'b1;
          SoFOut  <= 1'b1;
          EoFOut  <= rdEntry.eof;
          DataOut <= rdEntry.data;
        end
        R_SEND: if (EoFOut) begin
          rState  <= R_GAP;
          ReqOut  <= 1'b0;
          ValOut  <= 1'b0;
          SoFOut  <= 1'b0;
          EoFOut  <= 1'b0;
          DataOut <= '0;
          gapCnt  <= GAP_W'(GAP_CYC - 1);
        end else begin
          SoFOut  <= 1'b0;
          EoFOut  <= rdEntry.eof;
          DataOut <= rdEntry.data;
        end
        R_GAP: if (gapCnt == '0) begin
          // Re-request straight out of the gap so ReqOut idles exactly GAP_CYC cycles.
          if (FrameCnt != '0) begin
            rState <= R_REQ;
            ReqOut <= 1'b1;
          end else begin
            rState <= R_IDLE;
          end
        end else begin
          gapCnt <= gapCnt - GAP_W'(1);
        end
        default: rState <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_queue.sv
// Directed self-checking bench for eth_tx_frame_queue (ADDR_W=4 so overflow is reachable).
module tb_eth_tx_frame_queue;

  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 4;
  localparam int GAP_CYC = 2;

  logic             Clk = 1'b0;
  logic             nRst = 1'b1;
  logic             ValIn = 1'b0, SoFIn = 1'b0, EoFIn = 1'b0, Grant = 1'b0;
  logic [7:0]       DataIn = '0;
  logic             ReqOut, ValOut, SoFOut, EoFOut, DropPulse;
  logic [7:0]       DataOut;
  logic [CNT_W-1:0] FrameCnt;

  int nChecks = 0;
  int nErrs   = 0;

  logic [9:0] beats[$];
  logic [9:0] expBeats[$];
  int         gaps[$];
  int         lowRun  = 0;
  int         dropCnt = 0;
  logic       prevReq = 1'b0;

  eth_tx_frame_queue #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
    .Clk(Clk), .nRst(nRst), .ValIn(ValIn), .SoFIn(SoFIn), .EoFIn(EoFIn), .DataIn(DataIn),
    .Grant(Grant), .ReqOut(ReqOut), .ValOut(ValOut), .SoFOut(SoFOut), .EoFOut(EoFOut),
    .DataOut(DataOut), .FrameCnt(FrameCnt), .DropPulse(DropPulse)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (ValOut) beats.push_back({SoFOut, EoFOut, DataOut});
    if (DropPulse) dropCnt++;
    if (ReqOut && !prevReq) begin
      gaps.push_back(lowRun);
      lowRun = 0;
    end
    if (!ReqOut) lowRun++;
    prevReq = ReqOut;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // n bytes from base; SoF on the first, EoF on the last when withEof is set.
  task automatic writeBytes(input int n, input logic [7:0] base, input bit withEof);
    for (int i = 0; i < n; i++) begin
      ValIn  = 1'b1;
      SoFIn  = (i == 0);
      EoFIn  = withEof && (i == n - 1);
      DataIn = base + 8'(i);
      tick();
    end
    ValIn = 1'b0; SoFIn = 1'b0; EoFIn = 1'b0; DataIn = '0;
  endtask

  task automatic waitReq(input string tag);
    int k = 0;
    while (!ReqOut && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(ReqOut), 32'd1);
  endtask

  task automatic checkBeats(input string tag);
    chk({tag, ".count"}, 32'(beats.size()), 32'(expBeats.size()));
    for (int i = 0; i < expBeats.size(); i++)
      if (i < beats.size()) chk(tag, 32'(beats[i]), 32'(expBeats[i]));
  endtask

  function automatic logic [9:0] bt(input logic s, input logic e, input logic [7:0] d);
    return {s, e, d};
  endfunction

  initial begin
    #2 nRst = 1'b0;
    tick(3);
    chk("rst.outs", 32'({ReqOut, ValOut, SoFOut, EoFOut, DataOut, DropPulse}), 32'd0);
    chk("rst.cnt", 32'(FrameCnt), 32'd0);
    nRst = 1'b1;
    tick(4);
    chk("rel.req", 32'(ReqOut), 32'd0);
    chk("rel.cnt", 32'(FrameCnt), 32'd0);

    // 1) 4-byte frame, cycle-exact stream after the grant
    writeBytes(4, 8'hA0, 1'b1);
    chk("t1.cnt", 32'(FrameCnt), 32'd1);
    tick();
    chk("t1.req", 32'(ReqOut), 32'd1);
    tick(2);
    chk("t1.noval", 32'(ValOut), 32'd0);
    Grant = 1'b1;
    tick();
    Grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1.val", 32'(ValOut), 32'd1);
      chk("t1.beat", 32'({SoFOut, EoFOut, DataOut}), 32'(bt(i == 0, i == 3, 8'hA0 + 8'(i))));
      tick();
    end
    chk("t1.reqoff", 32'(ReqOut), 32'd0);
    chk("t1.valoff", 32'(ValOut), 32'd0);
    chk("t1.cntoff", 32'(FrameCnt), 32'd0);

    // 2) three 1-byte frames with Grant held high
    tick(4);
    beats.delete(); gaps.delete(); expBeats.delete();
    Grant = 1'b1;
    writeBytes(1, 8'hB0, 1'b1);
    writeBytes(1, 8'hB1, 1'b1);
    writeBytes(1, 8'hB2, 1'b1);
    tick(25);
    Grant = 1'b0;
    expBeats = '{bt(1, 1, 8'hB0), bt(1, 1, 8'hB1), bt(1, 1, 8'hB2)};
    checkBeats("t2.beats");
    chk("t2.rises", 32'(gaps.size()), 32'd3);
    if (gaps.size() == 3) begin
      chk("t2.gap1", 32'(gaps[1]), 32'(GAP_CYC));
      chk("t2.gap2", 32'(gaps[2]), 32'(GAP_CYC));
    end
    chk("t2.cnt", 32'(FrameCnt), 32'd0);

    // 3) 20-byte frame overflows a 16-entry RAM; next frame is intact
    beats.delete(); gaps.delete(); expBeats.delete(); dropCnt = 0;
    writeBytes(20, 8'h10, 1'b1);
    tick(4);
    chk("t3.drops", 32'(dropCnt), 32'd1);
    chk("t3.cnt", 32'(FrameCnt), 32'd0);
    chk("t3.noreq", 32'(gaps.size()), 32'd0);
    chk("t3.req", 32'(ReqOut), 32'd0);
    writeBytes(3, 8'hC0, 1'b1);
    Grant = 1'b1;
    tick(10);
    Grant = 1'b0;
    expBeats = '{bt(1, 0, 8'hC0), bt(0, 0, 8'hC1), bt(0, 1, 8'hC2)};
    checkBeats("t3.beats");
    chk("t3.drops2", 32'(dropCnt), 32'd1);

    // 4) SoF inside an unfinished frame restarts it
    tick(4);
    beats.delete(); expBeats.delete(); dropCnt = 0;
    writeBytes(3, 8'hD0, 1'b0);
    writeBytes(2, 8'hE0, 1'b1);
    tick(2);
    chk("t4.drops", 32'(dropCnt), 32'd1);
    chk("t4.cnt", 32'(FrameCnt), 32'd1);
    Grant = 1'b1;
    tick(8);
    Grant = 1'b0;
    expBeats = '{bt(1, 0, 8'hE0), bt(0, 1, 8'hE1)};
    checkBeats("t4.beats");
    chk("t4.cntoff", 32'(FrameCnt), 32'd0);

    // 5) commit lands on the same edge as the EoF beat of the frame in flight
    tick(4);
    beats.delete(); expBeats.delete();
    writeBytes(2, 8'h60, 1'b1);
    waitReq("t5.waitreq");
    Grant = 1'b1;
    tick();
    Grant = 1'b0;
    tick();
    chk("t5.eofbeat", 32'(EoFOut), 32'd1);
    writeBytes(1, 8'h70, 1'b1);
    chk("t5.cnt", 32'(FrameCnt), 32'd1);
    chk("t5.gapreq1", 32'(ReqOut), 32'd0);
    tick();
    chk("t5.gapreq2", 32'(ReqOut), 32'd0);
    tick();
    chk("t5.rearm", 32'(ReqOut), 32'd1);
    Grant = 1'b1;
    tick(3);
    Grant = 1'b0;
    expBeats = '{bt(1, 0, 8'h60), bt(0, 1, 8'h61), bt(1, 1, 8'h70)};
    checkBeats("t5.beats");
    chk("t5.cntoff", 32'(FrameCnt), 32'd0);

    // 6) reset while streaming
    tick(4);
    writeBytes(6, 8'h80, 1'b1);
    waitReq("t6.waitreq");
    Grant = 1'b1;
    tick();
    Grant = 1'b0;
    tick();
    chk("t6.midsend", 32'(ValOut), 32'd1);
    #2 nRst = 1'b0;
    #1;
    chk("t6.outs", 32'({ReqOut, ValOut, SoFOut, EoFOut, DataOut, DropPulse}), 32'd0);
    chk("t6.cnt", 32'(FrameCnt), 32'd0);
    tick(2);
    nRst = 1'b1;
    tick(4);
    chk("t6.relreq", 32'(ReqOut), 32'd0);
    chk("t6.relcnt", 32'(FrameCnt), 32'd0);
    tick(5);
    chk("t6.idlereq", 32'(ReqOut), 32'd0);
    beats.delete(); expBeats.delete();
    writeBytes(1, 8'h90, 1'b1);
    tick(2);
    chk("t6.newcnt", 32'(FrameCnt), 32'd1);
    chk("t6.newreq", 32'(ReqOut), 32'd1);
    Grant = 1'b1;
    tick(3);
    Grant = 1'b0;
    expBeats = '{bt(1, 1, 8'h90)};
    checkBeats("t6.beats");

    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end

endmodule
